hamming_tx_framer: RTL
======================

// Module: hamming_tx_framer
// PURPOSE
//  Transmit-side counterpart of the link receive path: accepts a 16-bit word, Hamming(21,16)-encodes it,
//  and packs it into a 24-bit frame {3'b0, code[20:0]}. Issues the frame as 3 bytes, MSB byte first,
//  to the byte-level UART TX (i_TX_DV/i_TX_Byte/o_TX_Done). Sits between the core and UART_TX.
// PARAMETERS
//  DATA_WIDTH   16  payload width; only 16 is supported, elaboration error otherwise
//  CODE_WIDTH   21  Hamming code width (5 parity bits at positions 1,2,4,8,16)
//  FRAME_BYTES  3   bytes per frame
// PORTS
//  clk              in   1   system clock; all flops on falling edge (UART sees stable data on rising)
//  rstb             in   1   asynchronous, active-low reset
//  data_send        in   16  payload word
//  data_send_valid  in   1   payload valid
//  data_send_ready  out  1   high only in IDLE; word accepted on valid && ready
//  tx_byte          out  8   byte to UART_TX i_TX_Byte
//  tx_byte_valid    out  1   one-cycle pulse to UART_TX i_TX_DV
//  tx_done          in   1   UART_TX o_TX_Done pulse
//  busy             out  1   high from acceptance until the 3rd tx_done is consumed
// BEHAVIOUR
//  Reset: state=IDLE, byte_idx=0, code_reg=0, tx_byte=0, tx_byte_valid=0, busy=0, data_send_ready=1.
//  Encoding: code position p (1..21) maps to code[p-1]; data[0..15] fill non-power-of-2 positions
//   3,5,6,7,9..15,17..21 in ascending order; parity bit at 2^k = XOR of positions with bit k set (even).
//  Frame byte order: byte0={3'b000,code[20:16]}, byte1=code[15:8], byte2=code[7:0].
//  FSM:
//   IDLE   : ready=1. On data_send_valid: latch data_send -> ENCODE; busy=1, ready=0.
//   ENCODE : register code_reg=encode(data); byte_idx=0 -> ISSUE.
//   ISSUE  : drive tx_byte=frame byte[byte_idx], tx_byte_valid=1 for exactly this cycle -> WAIT.
//   WAIT   : tx_byte_valid=0. On tx_done: if byte_idx==2 -> IDLE (busy=0, ready=1) else byte_idx++ -> ISSUE.
//  Latency: first tx_byte_valid pulse starts on the 2nd clk edge after acceptance; next byte issued
//   1 cycle after each tx_done; ready re-asserts 1 cycle after the 3rd tx_done.
//  Boundaries:
//   - tx_done outside WAIT (IDLE, ENCODE, ISSUE) is ignored; no counter change.
//   - data_send_valid while busy is not accepted; data_send may change freely (payload already latched).
//   - back-to-back: valid held high in the cycle ready returns -> accepted immediately, no gap cycle.
//   - tx_byte holds its last value between pulses; only tx_byte_valid qualifies it.
//   - rstb asserted mid-frame: immediate return to reset values; partial frame abandoned, no resume.
// CONFIGURATION
//  HAMMING_TX_SECDED_EN: when defined, frame bit 21 = XOR of code[20:0] (overall even parity, SECDED),
//   i.e. byte0={2'b00,^code,code[20:16]}. When undefined, bit 21 = 0. All other behaviour identical.
// STRUCTURE
//  Package hamming_pkg: DATA_W/CODE_W/FRAME_BYTES constants, tx_framer_state_t enum
//   {IDLE,ENCODE,ISSUE,WAIT}, parity-position constants, shared with the receive-side decoder.
//  Sub-module hamming_enc: combinational 16->21 encoder, instanced once; FSM and byte mux in this file.
// TESTING
//  1 reset mid-WAIT (after byte0) -> all outputs at reset values; next word sends full 3 bytes from byte0.
//  2 data_send=16'h0000 -> bytes 0x00,0x00,0x00; ready low until 3rd tx_done, then high next cycle.
//  3 data_send=16'hFFFF -> code=21'h1FFFFE -> bytes 0x1F,0xFF,0xFE (same with SECDED_EN, parity=0).
//  4 data_send=16'h0001 -> bytes 0x00,0x00,0x07; with HAMMING_TX_SECDED_EN byte0=0x20.
//  5 spurious tx_done in IDLE and ISSUE -> ignored; byte count and byte order unaffected.
//  6 loopback through UART_TX/UART_RX + decoder, 1000 random words back-to-back -> all decode equal.

Source files
------------

// File: rtl/hamming_pkg.sv
// Hamming(21,16) constants, link frame layout and transmit-framer state encoding.
// Shared between the transmit framer and the receive-side decoder.
package hamming_pkg;

    localparam int unsigned DATA_W       = 16;
    localparam int unsigned CODE_W       = 21;
    localparam int unsigned PARITY_W     = 5;
    localparam int unsigned FRAME_BYTES  = 3;
    localparam int unsigned FRAME_W      = 8 * FRAME_BYTES;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned LAST_IDX     = FRAME_BYTES - 1;
    localparam int unsigned CODE_IDX_W   = $clog2(CODE_W);
    localparam int unsigned DATA_IDX_W   = $clog2(DATA_W);
    localparam int unsigned PARITY_IDX_W = $clog2(PARITY_W);

    // 1-based code positions: parity at powers of two, data[0..15] in the rest, ascending
    localparam int unsigned PARITY_POS [PARITY_W] = '{1, 2, 4, 8, 16};
    localparam int unsigned DATA_POS   [DATA_W]   = '{3, 5, 6, 7, 9, 10, 11, 12,
                                                      13, 14, 15, 17, 18, 19, 20, 21};

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        ISSUE,
        WAIT
    } tx_framer_state_t;

    typedef struct packed {
        logic [1:0]        rsvd;
        logic              secded;
        logic [CODE_W-1:0] code;
    } hamming_frame_t;

endpackage

// File: rtl/hamming_enc.sv
// Combinational Hamming(21,16) encoder; code position p maps to o_code[p-1], even parity.
module hamming_enc
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic [CODE_W-1:0] o_code
);

    logic [CODE_W-1:0] w_code;
    logic              w_par;

    // Scatter data into non-parity slots, then fill each parity slot from the positions it covers
    always_comb begin
        w_code = '0;
        w_par  = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            w_code[CODE_IDX_W'(DATA_POS[DATA_IDX_W'(i)] - 1)] = i_data[DATA_IDX_W'(i)];
        end
        for (int unsigned k = 0; k < PARITY_W; k++) begin
            w_par = 1'b0;
            for (int unsigned p = 1; p <= CODE_W; p++) begin
                if ((p & PARITY_POS[PARITY_IDX_W'(k)]) != 0) begin
                    w_par = w_par ^ w_code[CODE_IDX_W'(p - 1)];
                end
            end
            w_code[CODE_IDX_W'(PARITY_POS[PARITY_IDX_W'(k)] - 1)] = w_par;
        end
    end

    assign o_code = w_code;

endmodule

// File: rtl/hamming_tx_framer.sv
// Transmit framer: Hamming(21,16)-encodes a word and hands it to UART_TX as 3 bytes, MSB byte first.
// Define HAMMING_TX_SECDED_EN to carry overall even parity of the code in frame bit 21.
module hamming_tx_framer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned CODE_WIDTH  = 21,
    parameter int unsigned FRAME_BYTES = 3
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [DATA_WIDTH-1:0] data_send,
    input  logic                  data_send_valid,
    output logic                  data_send_ready,
    output logic [7:0]            tx_byte,
    output logic                  tx_byte_valid,
    input  logic                  tx_done,
    output logic                  busy
);

    import hamming_pkg::*;

    if (DATA_WIDTH != DATA_W || CODE_WIDTH != CODE_W ||
        FRAME_BYTES != hamming_pkg::FRAME_BYTES) begin : g_bad_cfg
        $error("hamming_tx_framer supports only DATA_WIDTH=16, CODE_WIDTH=21, FRAME_BYTES=3");
    end

    tx_framer_state_t      r_state;
    tx_framer_state_t      w_state_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CODE_W-1:0]     r_code;
    logic [CODE_W-1:0]     w_code;
    logic [CODE_W-1:0]     w_code_sel;
    logic                  w_secded;
    hamming_frame_t        w_frame;
    logic [IDX_W-1:0]      r_byte_idx;
    logic [IDX_W-1:0]      w_byte_idx_nxt;
    logic [7:0]            r_tx_byte;
    logic [7:0]            w_tx_byte_nxt;
    logic                  r_tx_byte_valid;
    logic                  r_busy;
    logic                  r_ready;
    logic                  w_accept;

    hamming_enc u_enc (
        .i_data (r_data),
        .o_code (w_code)
    );

    assign w_accept = (r_state == IDLE) && data_send_valid;

    // Byte 0 is issued in the same edge that registers the code, so take it straight from the encoder
    assign w_code_sel = (r_state == ENCODE) ? w_code : r_code;

`ifdef HAMMING_TX_SECDED_EN
    assign w_secded = ^w_code_sel;
`else
    assign w_secded = 1'b0;
`endif

    assign w_frame = '{rsvd: 2'b00, secded: w_secded, code: w_code_sel};

    // State register; UART samples on the rising edge, so everything here moves on the falling edge
    always_ff @(negedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (data_send_valid) w_state_nxt = ENCODE;
            ENCODE:  w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT: begin
                if (tx_done) begin
                    w_state_nxt = (r_byte_idx == IDX_W'(LAST_IDX)) ? IDLE : ISSUE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Byte index and byte mux; tx_byte only changes when a new byte is issued
    always_comb begin
        w_byte_idx_nxt = r_byte_idx;
        w_tx_byte_nxt  = r_tx_byte;
        case (r_state)
            ENCODE:  w_byte_idx_nxt = '0;
            WAIT: begin
                if (tx_done && (r_byte_idx != IDX_W'(LAST_IDX))) begin
                    w_byte_idx_nxt = r_byte_idx + IDX_W'(1);
                end
            end
            default: w_byte_idx_nxt = r_byte_idx;
        endcase
        if (w_state_nxt == ISSUE) begin
            case (w_byte_idx_nxt)
                IDX_W'(0): w_tx_byte_nxt = w_frame[23:16];
                IDX_W'(1): w_tx_byte_nxt = w_frame[15:8];
                default:   w_tx_byte_nxt = w_frame[7:0];
            endcase
        end
    end

    always_ff @(negedge clk or negedge rstb) begin
        if (!rstb) begin
            r_data          <= '0;
            r_code          <= '0;
            r_byte_idx      <= '0;
            r_tx_byte       <= '0;
            r_tx_byte_valid <= 1'b0;
            r_busy          <= 1'b0;
            r_ready         <= 1'b1;
        end else begin
            if (w_accept) begin
                r_data <= data_send;
            end
            if (r_state == ENCODE) begin
                r_code <= w_code;
            end
            r_byte_idx      <= w_byte_idx_nxt;
            r_tx_byte       <= w_tx_byte_nxt;
            r_tx_byte_valid <= (w_state_nxt == ISSUE);
            r_busy          <= (w_state_nxt != IDLE);
            r_ready         <= (w_state_nxt == IDLE);
        end
    end

    assign data_send_ready = r_ready;
    assign tx_byte         = r_tx_byte;
    assign tx_byte_valid   = r_tx_byte_valid;
    assign busy            = r_busy;

endmodule
